// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data main-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_LAT_DEF    = 2;
    localparam int unsigned STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data-port wins taken while the fetch port was waiting.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic f_req,
    input  logic f_win,
    input  logic d_win,
    output logic full_c
);

    localparam int unsigned CW = cnt_width(STARVE_MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (f_win || (idle && !f_req)) begin
            cnt <= '0;
        end else if (d_win && f_req && (cnt != CW'(STARVE_MAX))) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign full_c = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port main-memory arbiter between instruction fetch (F) and the MEM-stage data port (D).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m
);

    localparam int unsigned CNT_W = cnt_width(MEM_LAT);

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d, f_rdata_d, d_rdata_d;
    logic               f_gnt_d, d_gnt_d, f_rvalid_d, d_rvalid_d, mem_en_d;
    logic               idle_c, starve_full_c, f_win_c, d_win_c;

    // D wins by default; F wins alone or once D has starved it long enough.
    assign idle_c  = (state_q == IDLE);
    assign f_win_c = idle_c && f_req && (!d_req || starve_full_c);
    assign d_win_c = idle_c && d_req && !f_win_c;

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .idle   (idle_c),
        .f_req  (f_req),
        .f_win  (f_win_c),
        .d_win  (d_win_c),
        .full_c (starve_full_c)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        f_rdata_d   = f_rdata;
        d_rdata_d   = d_rdata;
        f_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        f_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        mem_en_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (f_win_c || d_win_c) begin
                    state_d    = ACCESS;
                    owner_d    = f_win_c ? OWN_F : OWN_D;
                    we_d       = d_win_c && d_we;
                    cnt_d      = CNT_W'(MEM_LAT - 1);
                    mem_addr_d = f_win_c ? f_addr : d_addr;
                    if (d_win_c) begin
                        mem_wdata_d = d_wdata;
                    end
                    f_gnt_d  = f_win_c;
                    d_gnt_d  = d_win_c;
                    mem_en_d = d_win_c && d_we;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                // Writes finish after the strobe cycle; reads wait for the memory latency.
                if (we_q || (cnt_q == '0)) begin
                    state_d    = DONE;
                    f_rvalid_d = (owner_q == OWN_F);
                    d_rvalid_d = (owner_q == OWN_D);
                    if (!we_q) begin
                        if (owner_q == OWN_F) begin
                            f_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_F;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            f_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            f_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            f_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            f_gnt     <= f_gnt_d;
            d_gnt     <= d_gnt_d;
            f_rvalid  <= f_rvalid_d;
            d_rvalid  <= d_rvalid_d;
            mem_en    <= mem_en_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            f_rdata   <= f_rdata_d;
            d_rdata   <= d_rdata_d;
        end
    end

    assign stall_f = f_req && !f_rvalid;
    assign stall_m = d_req && !d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2 main instance, MEM_LAT=1 side instance).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance, MEM_LAT = 2
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, stall_f, stall_m;
    logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] rd_q = '0;

    // Side instance, MEM_LAT = 1
    logic        f_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
    logic [31:0] f_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
    logic        f_gnt1, f_rvalid1, d_gnt1, d_rvalid1, mem_en1, stall_f1, stall_m1;
    logic [31:0] f_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rd_q),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .f_req(f_req1), .f_addr(f_addr1), .f_gnt(f_gnt1), .f_rvalid(f_rvalid1), .f_rdata(f_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .stall_f(stall_f1), .stall_m(stall_m1)
    );

    // Memory contents: address-derived pattern, one special word, plus the last write.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h40) ? 32'h1234_5678 : (32'hA000_0000 | a);
    endfunction

    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = '0, wr_data = '0;

    // Registered read: data for an address presented in cycle k is valid in cycle k+1.
    always @(posedge clk) begin
        rd_q <= (wr_valid && mem_addr == wr_addr) ? wr_data : pat(mem_addr);
        if (mem_en) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
    end

    assign mem_rdata1 = 32'hB000_0000 | mem_addr1;

    int gnt_viol = 0, rv_viol = 0, en_viol = 0, en_cycles = 0;

    always @(negedge clk) begin
        if (f_gnt && d_gnt)       gnt_viol  <= gnt_viol + 1;
        if (f_rvalid && d_rvalid) rv_viol   <= rv_viol + 1;
        if (mem_en && !d_gnt)     en_viol   <= en_viol + 1;
        if (mem_en)               en_cycles <= en_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngnt;
        int fk;
        int dk;
        int rv_after;

        repeat (3) @(posedge clk);
        #1;
        check("rst_f_gnt",    32'(f_gnt), 0);
        check("rst_d_rvalid", 32'(d_rvalid), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_f_rdata",  f_rdata, 0);
        rst = 1'b1;
        tick();

        // Lone fetch read
        f_req = 1'b1; f_addr = 32'h40;
        tick();
        check("t1_f_gnt",    32'(f_gnt), 1);
        check("t1_mem_addr", mem_addr, 32'h40);
        check("t1_stall_f",  32'(stall_f), 1);
        tick();
        check("t1_gnt_pulse",  32'(f_gnt), 0);
        check("t1_rv_early",   32'(f_rvalid), 0);
        tick();
        check("t1_f_rvalid",   32'(f_rvalid), 1);
        check("t1_f_rdata",    f_rdata, 32'h1234_5678);
        check("t1_stall_rv",   32'(stall_f), 0);
        f_req = 1'b0;
        tick();
        check("t1_rv_pulse",   32'(f_rvalid), 0);

        // Data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        tick();
        check("t2_d_gnt",     32'(d_gnt), 1);
        check("t2_mem_en",    32'(mem_en), 1);
        check("t2_mem_addr",  mem_addr, 32'h100);
        check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        check("t2_mem_en_off", 32'(mem_en), 0);
        check("t2_d_rvalid",   32'(d_rvalid), 1);
        check("t2_d_rdata",    d_rdata, 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // Both ports streaming reads: four D grants, then one F grant
        fk = 0; dk = 0; ngnt = 0;
        f_addr = 32'h0; d_addr = 32'h200;
        f_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 400 && (f_req || d_req); c++) begin
            tick();
            if (f_gnt || d_gnt) begin
                if (ngnt < 10) check($sformatf("t3_gnt%0d_is_f", ngnt), 32'(f_gnt), 32'((ngnt % 5) == 4));
                ngnt++;
            end
            if (f_rvalid) begin
                check("t3_f_rdata", f_rdata, pat(f_addr));
                fk++;
                if (ngnt >= 10) f_req = 1'b0;
                else f_addr = 32'(4 * fk);
            end
            if (d_rvalid) begin
                check("t3_d_rdata", d_rdata, pat(d_addr));
                dk++;
                if (ngnt >= 10) d_req = 1'b0;
                else d_addr = 32'h200 + 32'(4 * dk);
            end
        end
        check("t3_drained",      32'(f_req || d_req), 0);
        check("t3_gnt_per_acc",  32'(ngnt), 32'(fk + dk));
        tick();

        // D read then F read, both raised together
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        f_req = 1'b1; f_addr = 32'h8;
        tick();
        check("t4_d_gnt",     32'(d_gnt), 1);
        check("t4_f_no_gnt",  32'(f_gnt), 0);
        check("t4_stall_f0",  32'(stall_f), 1);
        tick();
        tick();
        check("t4_d_rvalid",  32'(d_rvalid), 1);
        check("t4_d_rdata",   d_rdata, 32'hDEAD_BEEF);
        check("t4_stall_f1",  32'(stall_f), 1);
        d_req = 1'b0;
        tick();
        check("t4_idle_gnt",  32'(f_gnt), 0);
        check("t4_stall_f2",  32'(stall_f), 1);
        tick();
        check("t4_f_gnt",     32'(f_gnt), 1);
        check("t4_stall_m1",  32'(stall_m), 0);
        tick();
        check("t4_stall_m2",  32'(stall_m), 0);
        tick();
        check("t4_f_rvalid",  32'(f_rvalid), 1);
        check("t4_f_rdata",   f_rdata, 32'hA000_0008);
        check("t4_stall_f3",  32'(stall_f), 0);
        f_req = 1'b0;
        tick();

        // Reset during the second ACCESS cycle of a read
        f_req = 1'b1; f_addr = 32'hC;
        tick();
        check("t5_f_gnt", 32'(f_gnt), 1);
        tick();
        #2;
        rst = 1'b0; f_req = 1'b0;
        #1;
        check("t5_f_gnt0",     32'(f_gnt), 0);
        check("t5_f_rvalid0",  32'(f_rvalid), 0);
        check("t5_mem_en0",    32'(mem_en), 0);
        check("t5_mem_addr0",  mem_addr, 0);
        check("t5_mem_wdata0", mem_wdata, 0);
        check("t5_f_rdata0",   f_rdata, 0);
        check("t5_d_rdata0",   d_rdata, 0);
        tick();
        rst = 1'b1;
        rv_after = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (f_rvalid || d_rvalid) rv_after++;
        end
        check("t5_no_rvalid", 32'(rv_after), 0);
        f_req = 1'b1; f_addr = 32'h10;
        tick();
        check("t5_regnt", 32'(f_gnt), 1);
        tick();
        tick();
        check("t5_rvalid", 32'(f_rvalid), 1);
        check("t5_rdata",  f_rdata, 32'hA000_0010);
        f_req = 1'b0;
        tick();

        // MEM_LAT=1 instance: read completes at N+2, write timing unchanged
        f_req1 = 1'b1; f_addr1 = 32'h20;
        tick();
        check("t6_f_gnt",    32'(f_gnt1), 1);
        check("t6_stall_f",  32'(stall_f1), 1);
        tick();
        check("t6_f_rvalid", 32'(f_rvalid1), 1);
        check("t6_f_rdata",  f_rdata1, 32'hB000_0020);
        f_req1 = 1'b0;
        tick();
        check("t6_rv_pulse", 32'(f_rvalid1), 0);
        d_req1 = 1'b1; d_we1 = 1'b1; d_addr1 = 32'h44; d_wdata1 = 32'hCAFE_F00D;
        tick();
        check("t6_d_gnt",     32'(d_gnt1), 1);
        check("t6_mem_en",    32'(mem_en1), 1);
        check("t6_mem_addr",  mem_addr1, 32'h44);
        check("t6_mem_wdata", mem_wdata1, 32'hCAFE_F00D);
        tick();
        check("t6_mem_en_off", 32'(mem_en1), 0);
        check("t6_d_rvalid",   32'(d_rvalid1), 1);
        check("t6_d_rdata",    d_rdata1, 0);
        d_req1 = 1'b0; d_we1 = 1'b0;
        tick();
        check("t6_stall_m", 32'(stall_m1), 0);

        tick();
        check("inv_one_gnt",    32'(gnt_viol), 0);
        check("inv_one_rvalid", 32'(rv_viol), 0);
        check("inv_en_first",   32'(en_viol), 0);
        check("inv_en_cycles",  32'(en_cycles), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
